// File: rtl/cpu15_io_ram.sv
// cpu15 data memory: word RAM below IO_BASE, output latches, synchronised
// input ports and a sticky read-to-clear change-flag register above it.
module cpu15_io_ram #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter int                IO_BASE = 64,
  parameter int                N_OUT   = 1,
  parameter int                N_IN    = 1,
  parameter logic [DATA_W-1:0] IN_MASK = 16'h03FF,
  parameter logic [DATA_W-1:0] OUT_INV = 16'hFC00
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WE,
  input  logic                      RE,
  input  logic [ADDR_W-1:0]         ADDR,
  input  logic [DATA_W-1:0]         WDATA,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      RVALID,
  input  logic [N_IN*DATA_W-1:0]    IO_IN,
  output logic [N_OUT*DATA_W-1:0]   IO_OUT
);

  localparam int RAM_AW = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IO_BASE + N_OUT);
  localparam logic [ADDR_W-1:0] CHG_A = ADDR_W'(IO_BASE + N_OUT + N_IN);

  logic [DATA_W-1:0]             mem_q [IO_BASE];
  logic [RAM_AW-1:0]             ram_idx;

  logic [N_OUT-1:0][DATA_W-1:0]  out_q, out_d;
  logic [N_IN-1:0][DATA_W-1:0]   sync1_q, sync2_q, prev_q;
  logic [N_IN-1:0]               flag_q, flag_d, chg_set;
  logic [1:0]                    arm_cnt_q, arm_cnt_d;
  logic                          armed;
  logic                          chg_rd;

  logic [DATA_W-1:0]             rd_mux, rdata_q, rdata_d;
  logic                          rvalid_q, rvalid_d;

  assign ram_idx = ADDR[RAM_AW-1:0];
  assign armed   = (arm_cnt_q == 2'd3);
  assign chg_rd  = RE && (ADDR == CHG_A);

  // RAM has no reset; a write coinciding with RESET is allowed to land.
  always_ff @(posedge CLK) begin
    if (WE && (ADDR < OUT_A)) begin
      mem_q[ram_idx] <= WDATA;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ADDR < OUT_A) begin
      rd_mux = mem_q[ram_idx];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (ADDR == OUT_A + ADDR_W'(k)) rd_mux = out_q[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (ADDR == IN_A + ADDR_W'(k)) rd_mux = sync2_q[k] & IN_MASK;
    end
    if (ADDR == CHG_A) begin
      rd_mux = DATA_W'(flag_q);
    end
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (WE && (ADDR == OUT_A + ADDR_W'(k))) out_d[k] = WDATA;
    end
  end

  always_comb begin
    chg_set = '0;
    for (int k = 0; k < N_IN; k++) begin
      chg_set[k] = armed && (((sync2_q[k] ^ prev_q[k]) & IN_MASK) != '0);
    end
  end

  // The clearing read removes only what it returned; a same-cycle change survives.
  always_comb begin
    flag_d    = (flag_q & ~(chg_rd ? flag_q : '0)) | chg_set;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
    rdata_d   = RE ? rd_mux : rdata_q;
    rvalid_d  = RE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      flag_q    <= '0;
      arm_cnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      sync1_q   <= IO_IN;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      flag_q    <= flag_d;
      arm_cnt_q <= arm_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    IO_OUT = '0;
    for (int k = 0; k < N_OUT; k++) begin
      IO_OUT[k*DATA_W +: DATA_W] = out_q[k] ^ OUT_INV;
    end
  end

  assign RDATA  = rdata_q;
  assign RVALID = rvalid_q;

endmodule

// File: tb/tb_cpu15_io_ram.sv
// Bench for cpu15_io_ram: directed test-plan sequences plus random traffic,
// checked every cycle against a pin-history reference model.
module tb_cpu15_io_ram;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WE, RE;
  logic [7:0]  ADDR;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        RVALID;
  logic [15:0] IO_IN;
  logic [15:0] IO_OUT;

  logic        WE2, RE2;
  logic [7:0]  ADDR2;
  logic [15:0] WDATA2;
  logic [15:0] RDATA2;
  logic        RVALID2;
  logic [47:0] IO_IN2;
  logic [31:0] IO_OUT2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  cpu15_io_ram dut (
    .CLK(CLK), .RESET(RESET), .WE(WE), .RE(RE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .RVALID(RVALID), .IO_IN(IO_IN), .IO_OUT(IO_OUT)
  );

  cpu15_io_ram #(.N_OUT(2), .N_IN(3)) dut2 (
    .CLK(CLK), .RESET(RESET), .WE(WE2), .RE(RE2), .ADDR(ADDR2), .WDATA(WDATA2),
    .RDATA(RDATA2), .RVALID(RVALID2), .IO_IN(IO_IN2), .IO_OUT(IO_OUT2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync value seen at an edge is the pin two edges back,
  // prev is the pin three edges back; flags armed from the 4th edge after reset.
  logic [15:0] m_mem [64];
  bit          m_memv [64];
  logic [15:0] m_out, m_rdata, p1, p2, p3, m_rv;
  logic        m_flag, m_rvalid, m_chg;
  bit          m_rknown, m_rk;
  int          m_rel;
  bit          mon_en = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_out = 0; m_flag = 0; m_rvalid = 0; m_rdata = 0; m_rknown = 1;
      p1 = 0; p2 = 0; p3 = 0; m_rel = 0;
      if (WE && ADDR < 8'd64) m_memv[ADDR[5:0]] = 0;
    end else begin
      m_rv = 0; m_rk = 1;
      if (ADDR < 8'd64) begin
        m_rv = m_mem[ADDR[5:0]]; m_rk = m_memv[ADDR[5:0]];
      end else if (ADDR == 8'd64) m_rv = m_out;
      else if (ADDR == 8'd65) m_rv = p2 & 16'h03FF;
      else if (ADDR == 8'd66) m_rv = {15'b0, m_flag};
      m_chg = (m_rel >= 3) && (((p2 ^ p3) & 16'h03FF) != 16'h0);
      if (RE && ADDR == 8'd66) m_flag = m_chg;
      else m_flag = m_flag | m_chg;
      if (WE && ADDR < 8'd64) begin
        m_mem[ADDR[5:0]] = WDATA; m_memv[ADDR[5:0]] = 1;
      end
      if (WE && ADDR == 8'd64) m_out = WDATA;
      m_rvalid = RE;
      if (RE) begin
        m_rdata = m_rv; m_rknown = m_rk;
      end
      p3 = p2; p2 = p1; p1 = IO_IN;
      if (m_rel < 3) m_rel++;
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("io_out", 32'(IO_OUT), 32'(m_out ^ 16'hFC00));
      check("rvalid", 32'(RVALID), 32'(m_rvalid));
      if (m_rknown) check("rdata", 32'(RDATA), 32'(m_rdata));
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [7:0] a, input logic [15:0] wd);
    WE = we; RE = re; ADDR = a; WDATA = wd;
    @(negedge CLK);
    WE = 0; RE = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 8'd0, 16'h0);
  endtask

  logic [7:0] ra;

  initial begin
    for (int i = 0; i < 64; i++) m_memv[i] = 0;
    RESET = 1; WE = 0; RE = 0; ADDR = 0; WDATA = 0; IO_IN = 16'h0155;
    WE2 = 0; RE2 = 0; ADDR2 = 0; WDATA2 = 0; IO_IN2 = '0;
    @(negedge CLK);
    mon_en = 1;
    @(negedge CLK);
    RESET = 0;

    check("rst_io_out", 32'(IO_OUT), 32'h0000FC00);
    check("rst_rvalid", 32'(RVALID), 32'h0);
    check("rst_rdata", 32'(RDATA), 32'h0);
    check("rst_io_out2", 32'(IO_OUT2), 32'hFC00FC00);
    cyc(0, 1, 8'd66, 16'h0);
    check("rst_chg", 32'(RDATA), 32'h0);
    idle(3);

    cyc(1, 0, 8'd3, 16'hA5A5);
    cyc(0, 1, 8'd3, 16'h0);
    check("ram_rvalid", 32'(RVALID), 32'h1);
    check("ram_rt", 32'(RDATA), 32'hA5A5);
    cyc(1, 1, 8'd3, 16'h1234);
    check("ram_rbw_old", 32'(RDATA), 32'hA5A5);
    cyc(0, 1, 8'd3, 16'h0);
    check("ram_rbw_new", 32'(RDATA), 32'h1234);
    idle(1);
    check("rvalid_drop", 32'(RVALID), 32'h0);
    check("rdata_hold", 32'(RDATA), 32'h1234);

    cyc(1, 0, 8'd64, 16'h00FF);
    check("out_pin", 32'(IO_OUT), 32'hFCFF);
    cyc(0, 1, 8'd64, 16'h0);
    check("out_readback", 32'(RDATA), 32'h00FF);

    IO_IN = 16'hFFFF;
    idle(1);
    cyc(0, 1, 8'd65, 16'h0);
    check("in_lat_old", 32'(RDATA), 32'h0155);
    cyc(0, 1, 8'd65, 16'h0);
    check("in_lat_new", 32'(RDATA), 32'h03FF);

    idle(2);
    cyc(0, 1, 8'd66, 16'h0);
    check("chg_set", 32'(RDATA), 32'h1);
    cyc(0, 1, 8'd66, 16'h0);
    check("chg_clr", 32'(RDATA), 32'h0);

    IO_IN = IO_IN ^ 16'h0001;
    idle(4);
    IO_IN = IO_IN ^ 16'h0001;
    idle(2);
    cyc(0, 1, 8'd66, 16'h0);
    check("race_first", 32'(RDATA), 32'h1);
    cyc(0, 1, 8'd66, 16'h0);
    check("race_survive", 32'(RDATA), 32'h1);
    cyc(0, 1, 8'd66, 16'h0);
    check("race_cleared", 32'(RDATA), 32'h0);

    cyc(1, 0, 8'd65, 16'h1111);
    cyc(1, 0, 8'd66, 16'hFFFF);
    cyc(1, 0, 8'd200, 16'hBEEF);
    cyc(0, 1, 8'd65, 16'h0);
    check("ign_in", 32'(RDATA), 32'h03FF);
    cyc(0, 1, 8'd66, 16'h0);
    check("ign_chg", 32'(RDATA), 32'h0);
    cyc(0, 1, 8'd200, 16'h0);
    check("unmapped", 32'(RDATA), 32'h0);
    check("ign_out", 32'(IO_OUT), 32'hFCFF);

    WE2 = 1; ADDR2 = 8'd65; WDATA2 = 16'h0F0F;
    idle(1);
    WE2 = 0;
    check("p2_out1", 32'(IO_OUT2), 32'hF30FFC00);
    IO_IN2 = 48'h0001_0000_0000;
    idle(3);
    RE2 = 1; ADDR2 = 8'd69;
    idle(1);
    check("p2_chg69", 32'(RDATA2), 32'h4);
    idle(1);
    check("p2_chg69_clr", 32'(RDATA2), 32'h0);
    ADDR2 = 8'd68;
    idle(1);
    check("p2_in2", 32'(RDATA2), 32'h0001);
    ADDR2 = 8'd70;
    idle(1);
    check("p2_unmapped", 32'(RDATA2), 32'h0);
    RE2 = 0;

    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 8'($urandom_range(0, 7));
        1: ra = 8'd64;
        2: ra = 8'd65;
        3: ra = 8'd66;
        4: ra = 8'($urandom_range(67, 255));
        default: ra = 8'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 5) == 0) IO_IN = 16'($urandom);
      RESET = ($urandom_range(0, 99) < 2);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra, 16'($urandom));
    end
    RESET = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
